// File: rtl/brch_ckpt_fifo_if.sv
// Allocation-stage branch checkpoint bus: branch inserts, ROB commit/mispredict
// in, occupancy and recovery information out.
interface brch_ckpt_fifo_if #(
    parameter int DEPTH = 4,
    parameter int LANES = 4,
    parameter int IDX_W = 6,
    parameter int POS_W = 7,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic [LANES-1:0]       brch_in;
    logic [LANES*IDX_W-1:0] brch_idx_in;
    logic [LANES*POS_W-1:0] brch_pos_in;
    logic                   cmt_brch;
    logic [IDX_W-1:0]       cmt_brch_indx;
    logic                   mis_pred;
    logic [IDX_W-1:0]       brch_mis_indx;
    logic                   ful_out;
    logic [CNT_W-1:0]       cnt_out;
    logic                   rcvr_vld_out;
    logic [POS_W-1:0]       rcvr_pos_out;
    logic [IDX_W-1:0]       rcvr_idx_out;
    logic [2:0]             err_out;

    modport master (
        output brch_in, brch_idx_in, brch_pos_in, cmt_brch, cmt_brch_indx,
               mis_pred, brch_mis_indx,
        input  ful_out, cnt_out, rcvr_vld_out, rcvr_pos_out, rcvr_idx_out, err_out
    );

    modport slave (
        input  brch_in, brch_idx_in, brch_pos_in, cmt_brch, cmt_brch_indx,
               mis_pred, brch_mis_indx,
        output ful_out, cnt_out, rcvr_vld_out, rcvr_pos_out, rcvr_idx_out, err_out
    );
endinterface

// File: rtl/brch_ckpt_fifo.sv
// Branch checkpoint FIFO: in-order ring of {ROB idx, rename pos} per in-flight
// branch, with in-order commit and mispredict truncation/recovery.
module brch_ckpt_fifo #(
    parameter int DEPTH = 4,
    parameter int LANES = 4,
    parameter int IDX_W = 6,
    parameter int POS_W = 7,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    brch_ckpt_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + 1;

    logic [IDX_W-1:0] r_idx [DEPTH];
    logic [POS_W-1:0] r_pos [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rcvr_vld;
    logic [POS_W-1:0] r_rcvr_pos;
    logic [IDX_W-1:0] r_rcvr_idx;
    logic [2:0]       r_err;

    logic [CNT_W-1:0] w_n;
    logic [PTR_W-1:0] w_lane_slot [LANES];
    logic [PTR_W-1:0] w_off [DEPTH];
    logic             w_hit;
    logic [PTR_W-1:0] w_hit_slot;
    logic [PTR_W-1:0] w_dist;
    logic             w_cmt_ok;
    logic [CNT_W-1:0] w_cnt_post;
    logic [SUM_W-1:0] w_sum;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ins_en;
    logic [2:0]       w_err_set;

    // Compaction: each valid lane takes the next free slot after the ones before it.
    always_comb begin
        w_n = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_slot[k] = r_tail + PTR_W'(w_n);
            if (bus.brch_in[k]) begin
                w_n = w_n + CNT_W'(1);
            end else begin
                w_n = w_n;
            end
        end
    end

    // Mispredict search over the live window [head, head+count).
    always_comb begin
        w_hit      = 1'b0;
        w_hit_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i] = PTR_W'(i) - r_head;
            if ((CNT_W'(w_off[i]) < r_cnt) && (r_idx[i] == bus.brch_mis_indx)) begin
                w_hit      = 1'b1;
                w_hit_slot = PTR_W'(i);
            end else begin
                w_hit      = w_hit;
                w_hit_slot = w_hit_slot;
            end
        end
    end

    assign w_dist   = w_hit_slot - r_head;
    assign w_cmt_ok = bus.cmt_brch && (r_cnt != '0) && (r_idx[r_head] == bus.cmt_brch_indx);

    // Next pointer/count and error events; a mispredict squashes same-cycle inserts.
    always_comb begin
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        w_cnt_nxt  = r_cnt;
        w_cnt_post = r_cnt;
        w_sum      = '0;
        w_ins_en   = 1'b0;
        w_err_set  = 3'b000;
        if (bus.mis_pred) begin
            if (w_hit) begin
                w_tail_nxt = w_hit_slot;
                if (w_hit_slot == r_head) begin
                    // The head itself is the mispredict: a matching commit is moot.
                    w_cnt_nxt    = '0;
                    w_err_set[1] = bus.cmt_brch && !w_cmt_ok;
                end else if (w_cmt_ok) begin
                    w_head_nxt = r_head + PTR_W'(1);
                    w_cnt_nxt  = CNT_W'(w_dist) - CNT_W'(1);
                end else begin
                    w_cnt_nxt    = CNT_W'(w_dist);
                    w_err_set[1] = bus.cmt_brch;
                end
            end else begin
                w_err_set[2] = 1'b1;
                if (w_cmt_ok) begin
                    w_head_nxt = r_head + PTR_W'(1);
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                end else begin
                    w_err_set[1] = bus.cmt_brch;
                end
            end
        end else begin
            if (w_cmt_ok) begin
                w_head_nxt = r_head + PTR_W'(1);
                w_cnt_post = r_cnt - CNT_W'(1);
            end else begin
                w_err_set[1] = bus.cmt_brch;
            end
            w_sum = SUM_W'(w_cnt_post) + SUM_W'(w_n);
            if (w_n == '0) begin
                w_cnt_nxt = w_cnt_post;
            end else if (w_sum > SUM_W'(DEPTH)) begin
                w_cnt_nxt    = w_cnt_post;
                w_err_set[0] = 1'b1;
            end else begin
                w_ins_en   = 1'b1;
                w_tail_nxt = r_tail + PTR_W'(w_n);
                w_cnt_nxt  = CNT_W'(w_sum);
            end
        end
    end

    // State, entry storage, recovery pulse and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_cnt      <= '0;
            r_rcvr_vld <= 1'b0;
            r_rcvr_pos <= '0;
            r_rcvr_idx <= '0;
            r_err      <= 3'b000;
            for (int i = 0; i < DEPTH; i++) begin
                r_idx[i] <= '0;
                r_pos[i] <= '0;
            end
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err      <= r_err | w_err_set;
            r_rcvr_vld <= bus.mis_pred && w_hit;
            if (bus.mis_pred && w_hit) begin
                r_rcvr_pos <= r_pos[w_hit_slot];
                r_rcvr_idx <= r_idx[w_hit_slot];
            end else begin
                r_rcvr_pos <= r_rcvr_pos;
                r_rcvr_idx <= r_rcvr_idx;
            end
            for (int k = 0; k < LANES; k++) begin
                if (w_ins_en && bus.brch_in[k]) begin
                    r_idx[w_lane_slot[k]] <= bus.brch_idx_in[k*IDX_W +: IDX_W];
                    r_pos[w_lane_slot[k]] <= bus.brch_pos_in[k*POS_W +: POS_W];
                end else begin
                    r_idx[w_lane_slot[k]] <= r_idx[w_lane_slot[k]];
                    r_pos[w_lane_slot[k]] <= r_pos[w_lane_slot[k]];
                end
            end
        end
    end

    assign bus.cnt_out      = r_cnt;
    assign bus.ful_out      = (SUM_W'(DEPTH) - SUM_W'(r_cnt)) < SUM_W'(LANES);
    assign bus.rcvr_vld_out = r_rcvr_vld;
    assign bus.rcvr_pos_out = r_rcvr_pos;
    assign bus.rcvr_idx_out = r_rcvr_idx;
    assign bus.err_out      = r_err;
endmodule
